// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - shared constants, state encoding and helpers for the 1-Wire bus master
// Contents: counter width, default slot timings (1 cycle = 1 us), FSM state codes,
// ROM command codes, and a helper that turns a cycle count into a terminal counter value.
package ow_pkg;

  localparam int CNT_W = 10;

  localparam int unsigned OW_RST_LOW_CYC   = 480;
  localparam int unsigned OW_RST_WAIT_CYC  = 480;
  localparam int unsigned OW_PRES_SAMPLE   = 70;
  localparam int unsigned OW_SLOT_CYC      = 60;
  localparam int unsigned OW_WR1_LOW       = 6;
  localparam int unsigned OW_WR0_LOW       = 55;
  localparam int unsigned OW_READ_SLOT_CYC = 61;
  localparam int unsigned OW_READ_INIT_LOW = 2;

  typedef logic [2:0] ow_state_t;

  localparam ow_state_t ST_IDLE     = 3'd0;
  localparam ow_state_t ST_RST_LOW  = 3'd1;
  localparam ow_state_t ST_RST_WAIT = 3'd2;
  localparam ow_state_t ST_CMD_SLOT = 3'd3;
  localparam ow_state_t ST_READ     = 3'd4;
  localparam ow_state_t ST_FIN      = 3'd5;

  localparam logic [7:0] READ_ROM = 8'h33;
  localparam logic [7:0] SKIP_ROM = 8'hCC;

  // Counter value on the last cycle of a window that is cyc cycles long.
  function automatic logic [CNT_W-1:0] cyc_last(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/ow_slot_timer.sv
// rtl/ow_slot_timer.sv - up-counter with synchronous clear and terminal-count compare
// Ports: clk, rst (async, active high), clear (next count = 0), end_val (terminal value),
// count (current cycle within window), tick_end (count == end_val).
module ow_slot_timer
  import ow_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] end_val,
  output logic [CNT_W-1:0] count,
  output logic             tick_end
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick_end = (count == end_val);

endmodule

// File: rtl/ow_bus_master.sv
// rtl/ow_bus_master.sv - 1-Wire master: reset/presence, LSB-first ROM command, read-slot pacing
// Ports: clk, rst (async, active high), start, cmd[7:0], bus_in (synchronised bus level),
// done_reading_data (reader finished pulse) in; bus_drive_low (open-drain pull request),
// en_data_read (reader enable), busy, done (1-cycle end pulse), no_presence (sticky status) out.
module ow_bus_master
  import ow_pkg::*;
#(
  parameter int unsigned RST_LOW_CYC   = OW_RST_LOW_CYC,
  parameter int unsigned RST_WAIT_CYC  = OW_RST_WAIT_CYC,
  parameter int unsigned PRES_SAMPLE   = OW_PRES_SAMPLE,
  parameter int unsigned SLOT_CYC      = OW_SLOT_CYC,
  parameter int unsigned WR1_LOW       = OW_WR1_LOW,
  parameter int unsigned WR0_LOW       = OW_WR0_LOW,
  parameter int unsigned READ_SLOT_CYC = OW_READ_SLOT_CYC,
  parameter int unsigned READ_INIT_LOW = OW_READ_INIT_LOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       bus_in,
  input  logic       done_reading_data,
  output logic       bus_drive_low,
  output logic       en_data_read,
  output logic       busy,
  output logic       done,
  output logic       no_presence
);

  localparam logic [CNT_W-1:0] RST_LOW_END  = cyc_last(RST_LOW_CYC);
  localparam logic [CNT_W-1:0] RST_WAIT_END = cyc_last(RST_WAIT_CYC);
  localparam logic [CNT_W-1:0] SLOT_END     = cyc_last(SLOT_CYC);
  localparam logic [CNT_W-1:0] READ_END     = cyc_last(READ_SLOT_CYC);
  localparam logic [CNT_W-1:0] PRES_AT      = CNT_W'(PRES_SAMPLE);
  localparam logic [CNT_W-1:0] WR1_LIM      = CNT_W'(WR1_LOW);
  localparam logic [CNT_W-1:0] WR0_LIM      = CNT_W'(WR0_LOW);
  localparam logic [CNT_W-1:0] RD_INIT_LIM  = CNT_W'(READ_INIT_LOW);

  ow_state_t        state;
  logic [7:0]       cmd_q;
  logic [2:0]       bit_idx;
  logic             presence;
  logic             no_presence_q;

  logic             tmr_clear;
  logic [CNT_W-1:0] tmr_end;
  logic [CNT_W-1:0] cnt;
  logic             tmr_tick;
  logic [CNT_W-1:0] wr_low;

  // One timer serves every phase; the terminal value follows the state.
  always_comb begin
    tmr_end = '0;
    case (state)
      ST_RST_LOW:  tmr_end = RST_LOW_END;
      ST_RST_WAIT: tmr_end = RST_WAIT_END;
      ST_CMD_SLOT: tmr_end = SLOT_END;
      ST_READ:     tmr_end = READ_END;
      default:     tmr_end = '0;
    endcase
  end

  // Held at zero while idle/finishing so each phase starts counting from 0;
  // a terminal tick clears it for the next phase or the next slot (read slots wrap).
  assign tmr_clear = (state == ST_IDLE) || (state == ST_FIN) || tmr_tick ||
                     ((state == ST_READ) && done_reading_data);

  ow_slot_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .end_val  (tmr_end),
    .count    (cnt),
    .tick_end (tmr_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_q         <= '0;
      bit_idx       <= '0;
      presence      <= 1'b0;
      no_presence_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_q         <= cmd;
            no_presence_q <= 1'b0;
            presence      <= 1'b0;
            bit_idx       <= '0;
            state         <= ST_RST_LOW;
          end
        end
        ST_RST_LOW: begin
          if (tmr_tick) state <= ST_RST_WAIT;
        end
        ST_RST_WAIT: begin
          // A device answers by holding the released bus low.
          if (cnt == PRES_AT) presence <= ~bus_in;
          if (tmr_tick) begin
            if (presence) begin
              bit_idx <= '0;
              state   <= ST_CMD_SLOT;
            end else begin
              no_presence_q <= 1'b1;
              state         <= ST_FIN;
            end
          end
        end
        ST_CMD_SLOT: begin
          if (tmr_tick) begin
            if (bit_idx == 3'd7) state <= ST_READ;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_READ: begin
          if (done_reading_data) state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_low = cmd_q[bit_idx] ? WR1_LIM : WR0_LIM;

  // Decoded from registered state/counter, so reset releases the bus immediately.
  always_comb begin
    bus_drive_low = 1'b0;
    case (state)
      ST_RST_LOW:  bus_drive_low = 1'b1;
      ST_CMD_SLOT: bus_drive_low = (cnt < wr_low);
      ST_READ:     bus_drive_low = (cnt < RD_INIT_LIM);
      default:     bus_drive_low = 1'b0;
    endcase
  end

  assign en_data_read = (state == ST_READ);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_FIN);
  assign no_presence  = no_presence_q;

endmodule

// File: doc/ow_bus_master.md
Name: ow_bus_master

Overview:
1-Wire bus master sequencer that sits directly upstream of the 64-bit data reader (`data_reader`).
- On `start`: issues a reset pulse and samples presence.
- Shifts out an 8-bit ROM command (e.g. 0x33 Read ROM), LSB first, in timed write slots.
- Hands the bus to the reader by asserting `en_data_read`, generating the read-slot initiation pulses until `done_reading_data` returns.
- Bus is open-drain: this block only requests pull-low; the top level ties `bus_drive_low` to the tri-state pad.

Parameters:
- RST_LOW_CYC, 480, cycles bus held low for reset pulse (1 cycle = 1 us).
- RST_WAIT_CYC, 480, cycles bus released after reset pulse.
- PRES_SAMPLE, 70, cycle index within release window at which `bus_in` is sampled for presence.
- SLOT_CYC, 60, write-slot length in cycles.
- WR1_LOW, 6, low time for a write-1 bit.
- WR0_LOW, 55, low time for a write-0 bit (remaining SLOT_CYC-WR0_LOW cycles = recovery).
- READ_SLOT_CYC, 61, read-slot period; matches the reader's 0..60 slot counter.
- READ_INIT_LOW, 2, low time that initiates each read slot.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a transaction; accepted only in IDLE.
- cmd  input  8  ROM command; latched on accepted start.
- bus_in  input  1  bus level, already synchronised to clk at top level.
- done_reading_data  input  1  one-cycle pulse from the data reader on 64th bit.
- bus_drive_low  output  1  1 = pull bus low, 0 = release.
- en_data_read  output  1  enable to the data reader.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at end of transaction.
- no_presence  output  1  status: no device answered; held until next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, counters 0, latched cmd 0. Deasserting rst mid-transaction leaves the block in IDLE with the bus released. The reader is disabled because `en_data_read` is 0.
- States: IDLE, RST_LOW, RST_WAIT, CMD_SLOT, READ, FIN.
- IDLE:
  - start=1 at edge → latch cmd, clear no_presence, busy=1, go RST_LOW, cycle counter=0.
  - start while not IDLE is ignored.
- RST_LOW: bus_drive_low=1 for exactly RST_LOW_CYC cycles, then RST_WAIT with counter=0.
- RST_WAIT:
  - bus_drive_low=0 for RST_WAIT_CYC cycles.
  - At counter==PRES_SAMPLE, register presence = ~bus_in.
  - At end of window: presence → CMD_SLOT with bit index 0; else set no_presence=1 and go FIN.
- CMD_SLOT:
  - 8 slots of SLOT_CYC cycles, back-to-back, LSB first.
  - Within each slot, bus_drive_low=1 while counter < (bit ? WR1_LOW : WR0_LOW), else 0.
  - After slot 7 → READ.
- READ:
  - en_data_read=1 from the first READ cycle.
  - Read-slot counter runs 0..READ_SLOT_CYC-1 and wraps, starting at 0 on the same cycle en_data_read first goes high, in lockstep with the reader.
  - bus_drive_low=1 while read-slot counter < READ_INIT_LOW.
  - On the edge that samples done_reading_data=1: en_data_read<=0, bus_drive_low<=0, go FIN.
  - done_reading_data outside READ is ignored.
- FIN: one cycle; done=1, busy<=0, then IDLE.
- No timeout on READ; a hung reader is recovered only by rst.
- Counters sized for the largest parameter (≥10 bits); no wrap occurs within a state.

Decomposition:
- ow_pkg: state enum, default timing constants, command constants (READ_ROM=8'h33, SKIP_ROM=8'hCC).
- One sub-module, ow_slot_timer: loadable up-counter with `clear` and `tick_end` compare. It is shared by the reset, write-slot and read-slot timing.

Test Plan:
- Power-up: rst=1 → all outputs 0 while rst held. Pulse start=1 with cmd=8'h33; device model pulls low over cycles 20..140 of release window → bus_drive_low high exactly 480 cycles, no_presence=0.
- Command encoding: cmd=8'h33 → slot low times 6,6,55,55,6,6,55,55 cycles, each slot 60 cycles, no gaps.
- No device (bus_in always 1) → no CMD_SLOT activity, done pulses one cycle after RST_WAIT ends, no_presence=1 held until next start.
- Read phase: en_data_read rises after slot 7 with 2-cycle low every 61 cycles. Inject done_reading_data at any cycle → en_data_read and bus_drive_low 0 next edge, done pulse one cycle later, busy=0.
- Robustness: start asserted during CMD_SLOT is ignored, latched cmd unchanged. Assert rst midway through write slot 3 → bus released immediately, IDLE, busy=0.
- Integration with `data_reader` and a slave model returning ROM 64'h2800_0123_4567_8910: reader's memory equals the pattern and done fires once.
